seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DIV, default 50000, clock cycles per digit slot, legal minimum 2.
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = seg, dp and an are driven low-true, 0 = high-true.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 load  input  1  when high at a clk edge, data, dp_in and lzb are captured into the shadow register.
REQ-007 data  input  4*N_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
REQ-008 dp_in  input  N_DIGITS  decimal-point request per digit.
REQ-009 lzb  input  1  leading-zero blanking enable, captured with load.
REQ-010 seg  output  7  segments, seg[6]=a ... seg[0]=g.
REQ-011 dp  output  1  decimal-point segment.
REQ-012 an  output  N_DIGITS  digit enables; exactly one active per slot, or none when blanked.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 Prescaler counts 0..DIV-1 and wraps; tick is asserted on the cycle it equals DIV-1.
REQ-015 Digit index increments on tick and wraps N_DIGITS-1 -> 0.
REQ-016 Frame boundary = tick with index N_DIGITS-1; frame_done is high for exactly that one cycle.
REQ-017 Double buffering: load writes the shadow register and sets a pending flag; the active register does not change on load.
REQ-018 At a frame boundary with pending set: active <= shadow, pending cleared; the new content first appears in the slot for digit 0.
REQ-019 load coincident with a frame boundary: the copy uses the shadow value from before that edge, the new value lands in the shadow, and pending stays set for the next frame.
REQ-020 Back-to-back loads within one frame: last load wins; earlier values are never displayed.
REQ-021 Decode, active-high form (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-022 dp (active-high form) = active dp bit of the current digit.
REQ-023 Leading-zero blanking, when the active lzb = 1: digit k (k>=1) is blanked if its nibble and all higher nibbles are 0 and none of those digits has a dp bit set.
REQ-024 Digit 0 is never blanked.
REQ-025 Blanked digit: an all inactive, seg all off, dp off for that slot; slot timing is unchanged.
REQ-026 seg, dp and an are registered, updating one clk after the index changes; at most one an bit is active in any cycle.
REQ-027 ACTIVE_LOW=1 inverts seg, dp and an at the output register only; all internal logic is polarity-independent.

Reset
REQ-028 rst high clears prescaler, index, shadow, active and pending to 0 immediately (asynchronously), regardless of clk.
REQ-029 During reset and until the first post-reset edge: an, seg and dp are all inactive (all 1 when ACTIVE_LOW=1) and frame_done = 0.
REQ-030 Reset mid-frame or with pending set discards the pending data; after release, scanning restarts at digit 0 with prescaler 0, displaying 0 on every digit.

Verification (N_DIGITS=4, DIV=4, ACTIVE_LOW=1)
REQ-031 Reset, then load data=16'h12AF, dp_in=0, lzb=0 -> from the next frame, slots show digit0 seg=0111000 (F), digit1 0001000 (A), digit2 0010010 (2), digit3 1001111 (1); an cycles 1110, 1101, 1011, 0111, each held 4 clk.
REQ-032 Load 16'h0042 with lzb=1 -> digits 3 and 2 are blanked (an=1111, seg=1111111), digits 1 and 0 show 4 and 2; reload with dp_in=4'b0100 -> digit 2 shows 0 with dp=0, digit 3 stays blanked.
REQ-033 Load 16'h1111, then 16'h2222 in the same frame -> no slot ever shows 1; the next frame shows 2 on all digits.
REQ-034 Load asserted on the frame_done cycle -> the following frame shows the previous shadow, and the frame after that shows the new value.
REQ-035 Assert rst asynchronously mid-slot while pending -> outputs inactive within the reset; after release, zeros are displayed and the first frame_done occurs 16 clk later.
REQ-036 Run 10 frames with random loads -> frame_done pulses every 16 clk, never more than one an bit is active, and rerunning with ACTIVE_LOW=0 produces the exact bitwise inverse of seg, dp and an.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for an N_DIGITS-digit seven-segment display.
//   A prescaler divides clk into digit slots of DIV cycles each. A digit
//   index walks 0..N_DIGITS-1. The displayed content is double-buffered:
//   a load writes a shadow register, and the shadow is copied into the
//   active register only at a frame boundary, so a frame never mixes old
//   and new content.
//
// Parameters
//   N_DIGITS   number of digits, legal range 2..8
//   DIV        clk cycles per digit slot, legal minimum 2
//   ACTIVE_LOW 1: seg/dp/an are low-true, 0: high-true
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   load       capture data/dp_in/lzb into the shadow register
//   data       4*N_DIGITS hex nibbles, nibble k drives digit k
//   dp_in      decimal-point request per digit
//   lzb        leading-zero blanking enable, captured with load
//   seg        segments, seg[6]=a ... seg[0]=g (registered)
//   dp         decimal-point segment (registered)
//   an         digit enables, at most one active (registered)
//   frame_done one-cycle pulse on the last prescaler cycle of a frame
module seg7_scan_driver #(
   parameter int N_DIGITS   = 4,
   parameter int DIV        = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   data,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    lzb,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_done
);

   localparam int CW = $clog2(DIV);
   localparam int IW = $clog2(N_DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
   localparam logic          POL      = (ACTIVE_LOW != 0);

   // Scan timing
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic          tick;
   logic          frame_bound;

   // Double buffer
   logic [4*N_DIGITS-1:0] sh_data;
   logic [N_DIGITS-1:0]   sh_dp;
   logic                  sh_lzb;
   logic [4*N_DIGITS-1:0] act_data;
   logic [N_DIGITS-1:0]   act_dp;
   logic                  act_lzb;
   logic                  pending;

   // Current-digit view, high-true
   logic [N_DIGITS-1:0] blank_vec;
   logic                run_zero;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blank;
   logic [N_DIGITS-1:0] an_hot;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   assign tick        = (cnt == CNT_LAST);
   assign frame_bound = tick && (idx == IDX_LAST);
   // Decoded straight from the scan registers so that a load presented in
   // this cycle coincides with the boundary edge.
   assign frame_done  = frame_bound;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
      end
   end

   // The copy reads the shadow value from before this edge, so a load on the
   // boundary edge is kept for the next frame with pending still set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_data  <= '0;
         sh_dp    <= '0;
         sh_lzb   <= 1'b0;
         act_data <= '0;
         act_dp   <= '0;
         act_lzb  <= 1'b0;
         pending  <= 1'b0;
      end else begin
         if (frame_bound && pending) begin
            act_data <= sh_data;
            act_dp   <= sh_dp;
            act_lzb  <= sh_lzb;
         end
         if (load) begin
            sh_data <= data;
            sh_dp   <= dp_in;
            sh_lzb  <= lzb;
            pending <= 1'b1;
         end else if (frame_bound) begin
            pending <= 1'b0;
         end
      end
   end

   // Leading-zero blanking: walk down from the top digit while nibbles are
   // zero and no decimal point is requested. Digit 0 is never considered.
   always_comb begin
      blank_vec = '0;
      run_zero  = 1'b1;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         run_zero     = run_zero & (act_data[4*k +: 4] == 4'h0) & ~act_dp[k];
         blank_vec[k] = run_zero & act_lzb;
      end
   end

   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      an_hot    = '0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_nib   = act_data[4*k +: 4];
            cur_dp    = act_dp[k];
            cur_blank = blank_vec[k];
            an_hot[k] = 1'b1;
         end
      end
   end

   // Output stage: one cycle behind the index. Polarity is applied only here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= {7{POL}};
         dp  <= POL;
         an  <= {N_DIGITS{POL}};
      end else begin
         seg <= (cur_blank ? 7'h00 : hex_to_seg(cur_nib)) ^ {7{POL}};
         dp  <= (cur_dp & ~cur_blank) ^ POL;
         an  <= (cur_blank ? '0 : an_hot) ^ {N_DIGITS{POL}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with N_DIGITS=4, DIV=4. A second
//   instance with ACTIVE_LOW=0 shares all inputs and must always be the
//   bitwise inverse of the low-true instance.
module tb_seg7_scan_driver;

   localparam int ND = 4;

   // Low-true segment codes (abcdefg)
   localparam logic [6:0] L0 = 7'b0000001;
   localparam logic [6:0] L1 = 7'b1001111;
   localparam logic [6:0] L2 = 7'b0010010;
   localparam logic [6:0] L4 = 7'b1001100;
   localparam logic [6:0] LA = 7'b0001000;
   localparam logic [6:0] LF = 7'b0111000;
   localparam logic [6:0] LB = 7'b1111111;

   logic            clk;
   logic            rst;
   logic            load;
   logic [4*ND-1:0] data;
   logic [ND-1:0]   dp_in;
   logic            lzb;
   logic [6:0]      seg;
   logic            dp;
   logic [ND-1:0]   an;
   logic            frame_done;
   logic [6:0]      seg_h;
   logic            dp_h;
   logic [ND-1:0]   an_h;
   logic            frame_done_h;

   int n_checks = 0;
   int n_fail   = 0;

   seg7_scan_driver #(.N_DIGITS(ND), .DIV(4), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .lzb(lzb),
      .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
   );

   seg7_scan_driver #(.N_DIGITS(ND), .DIV(4), .ACTIVE_LOW(0)) dut_hi (
      .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .lzb(lzb),
      .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(frame_done_h)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a single-cycle load starting at the current negedge.
   task automatic load_vec(input logic [15:0] d, input logic [3:0] p, input logic z);
      data  = d;
      dp_in = p;
      lzb   = z;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   // Advance to the next cycle with frame_done high, bounded.
   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 40);
      if (!frame_done) check("fd_timeout", {31'd0, frame_done}, 32'd1);
   endtask

   // Called on a frame_done cycle. The next sample is still the tail of the
   // old digit-3 slot; the following 15 samples are the new frame, and the
   // last of those is again the frame_done cycle. load is released after the
   // boundary edge so a caller may present a load coincident with it.
   task automatic check_frame(input string tag, input logic [27:0] segs,
                              input logic [3:0] dpx, input logic [3:0] blank);
      int            slot;
      logic [3:0]    exp_an;
      logic [6:0]    exp_seg;
      logic          exp_dp;
      for (int t = 0; t < 16; t++) begin
         @(negedge clk);
         if (t == 0) load = 1'b0;
         if (t >= 1) begin
            slot    = (t - 1) / 4;
            exp_an  = blank[slot] ? 4'hF : ~(4'b0001 << slot);
            exp_seg = blank[slot] ? LB : segs[slot*7 +: 7];
            exp_dp  = blank[slot] ? 1'b1 : dpx[slot];
            check($sformatf("%s_d%0d_t%0d", tag, slot, t), {20'd0, an, exp_dp ? dp : dp, seg},
                  {20'd0, exp_an, exp_dp, exp_seg});
            check($sformatf("%s_fd_t%0d", tag, t), {31'd0, frame_done}, {31'd0, (t == 15)});
         end
      end
   endtask

   initial begin
      int n;
      int gap;
      rst   = 1'b1;
      load  = 1'b0;
      data  = '0;
      dp_in = '0;
      lzb   = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out", {19'd0, an, dp, seg, frame_done}, {19'd0, 4'hF, 1'b1, 7'h7F, 1'b0});
      check("rst_out_hi", {20'd0, an_h, dp_h, seg_h}, 32'd0);
      rst = 1'b0;
      #1 check("rst_rel_out", {20'd0, an, dp, seg}, {20'd0, 4'hF, 1'b1, 7'h7F});

      // 12AF without blanking
      wait_frame();
      @(negedge clk);
      load_vec(16'h12AF, 4'b0000, 1'b0);
      wait_frame();
      check_frame("hex12af", {L1, L2, LA, LF}, 4'hF, 4'b0000);

      // 0042 with leading-zero blanking
      @(negedge clk);
      load_vec(16'h0042, 4'b0000, 1'b1);
      wait_frame();
      check_frame("lzb0042", {LB, LB, L4, L2}, 4'hF, 4'b1100);

      // A decimal point on digit 2 stops blanking there, digit 3 stays blank
      @(negedge clk);
      load_vec(16'h0042, 4'b0100, 1'b1);
      wait_frame();
      check_frame("lzb_dp", {LB, L0, L4, L2}, 4'b1011, 4'b1000);

      // Back-to-back loads in one frame: last wins
      @(negedge clk);
      load_vec(16'h1111, 4'b0000, 1'b0);
      repeat (3) @(negedge clk);
      load_vec(16'h2222, 4'b0000, 1'b0);
      wait_frame();
      check_frame("last_wins", {L2, L2, L2, L2}, 4'hF, 4'b0000);

      // Load coincident with the frame boundary
      @(negedge clk);
      load_vec(16'hAAAA, 4'b0000, 1'b0);
      wait_frame();
      data  = 16'hFFFF;
      dp_in = 4'b0000;
      lzb   = 1'b0;
      load  = 1'b1;
      check_frame("coinc_old", {LA, LA, LA, LA}, 4'hF, 4'b0000);
      check_frame("coinc_new", {LF, LF, LF, LF}, 4'hF, 4'b0000);

      // Asynchronous reset mid-slot with a load pending
      @(negedge clk);
      load_vec(16'h1111, 4'b0000, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("arst_out", {19'd0, an, dp, seg, frame_done}, {19'd0, 4'hF, 1'b1, 7'h7F, 1'b0});
      check("arst_out_hi", {20'd0, an_h, dp_h, seg_h}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check("arst_rel", {19'd0, an, dp, seg, frame_done}, {19'd0, 4'hF, 1'b1, 7'h7F, 1'b0});
      // frame_done is high in the 16th cycle counted from release (15 edges)
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) check("arst_first", {20'd0, an, dp, seg}, {20'd0, 4'b1110, 1'b1, L0});
      end while (!frame_done && n < 40);
      check("arst_fd_delay", n, 15);
      check_frame("arst_zero", {L0, L0, L0, L0}, 4'hF, 4'b0000);

      // Random loads for 10 frames
      gap = 0;
      for (int c = 0; c < 160; c++) begin
         @(negedge clk);
         load  = ($urandom_range(0, 5) == 0);
         data  = 16'($urandom);
         dp_in = 4'($urandom_range(0, 15));
         lzb   = 1'($urandom_range(0, 1));
         gap++;
         if (frame_done) begin
            check("fd_period", gap, 16);
            gap = 0;
         end
         check("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
         check("pol_inverse", {20'd0, an_h, dp_h, seg_h}, {20'd0, ~an, ~dp, ~seg});
         check("fd_match", {31'd0, frame_done_h}, {31'd0, frame_done});
      end
      load = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
